// File: rtl/ram_init.sv
// ram_init -- line-wide RAM that fills itself with a counting pattern after reset.
//
// After rst_ni deasserts, an internal sequencer writes one line per clock,
// addresses 0..CACHE_DEPTH-1 ascending. Word j of line i holds
// i*(CACHE_LINE/32)+j. init_done_o rises one edge after the last line is
// written and stays high until the next reset. Reads are registered (one
// cycle latency) and return zeros while init is in progress or when addr_i
// lies outside the array.
//
// Optional feature macro: RAM_INIT_WRITE_EN
//   When defined, a write port is added. Writes are accepted only after
//   init_done_o is high and only for in-range addresses. A read of the
//   address being written in the same cycle returns the old contents.
//
// Ports:
//   clk_i        input   1           clock, rising edge
//   rst_ni       input   1           asynchronous active-low reset
//   addr_i       input   ADDR_WIDTH  read address
//   data_o       output  CACHE_LINE  registered read data
//   init_done_o  output  1           array holds its initial contents
//   wr_en_i      input   1           write enable        (RAM_INIT_WRITE_EN)
//   wr_addr_i    input   ADDR_WIDTH  write address       (RAM_INIT_WRITE_EN)
//   wr_data_i    input   CACHE_LINE  write data          (RAM_INIT_WRITE_EN)

module ram_init #(
  parameter int unsigned CACHE_LINE  = 128,
  parameter int unsigned CACHE_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH  = $clog2(CACHE_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [CACHE_LINE-1:0] data_o,
  output logic                  init_done_o
`ifdef RAM_INIT_WRITE_EN
  ,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [CACHE_LINE-1:0] wr_data_i
`endif
);

  localparam int unsigned           WORDS     = CACHE_LINE / 32;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CACHE_DEPTH - 1);
  // One bit wider than the address so the bound is representable for any depth.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(CACHE_DEPTH);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,  // writing one pattern line per clock
    ST_SETTLE = 2'd1,  // last line written; done flag rises on the next edge
    ST_DONE   = 2'd2   // array ready for reads
  } state_e;

  logic [CACHE_LINE-1:0] cache_mem [CACHE_DEPTH];

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] seq_addr_q,  seq_addr_d;
  logic                  init_done_q, init_done_d;
  logic [CACHE_LINE-1:0] data_q,      data_d;

  logic                  fill_we;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [CACHE_LINE-1:0] mem_wdata;

  // Initial content of line idx: 32-bit word j = idx*WORDS + j.
  function automatic logic [CACHE_LINE-1:0] init_line(input logic [ADDR_WIDTH-1:0] idx);
    logic [CACHE_LINE-1:0] line;
    logic [31:0]           word;
    line = {CACHE_LINE{1'b0}};
    for (int unsigned j = 0; j < WORDS; j++) begin
      word             = 32'(idx) * 32'(WORDS) + 32'(j);
      line[32*j +: 32] = word;
    end
    return line;
  endfunction

  // True when an address selects an existing line (matters for non-power-of-two depth).
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_EXT);
  endfunction

  // State, sequencer address, done flag and read data registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_FILL;
      seq_addr_q  <= {ADDR_WIDTH{1'b0}};
      init_done_q <= 1'b0;
      data_q      <= {CACHE_LINE{1'b0}};
    end else begin
      state_q     <= state_d;
      seq_addr_q  <= seq_addr_d;
      init_done_q <= init_done_d;
      data_q      <= data_d;
    end
  end

  // Next-state and sequencer address: step through every line, then settle.
  always_comb begin
    state_d    = state_q;
    seq_addr_d = seq_addr_q;
    case (state_q)
      ST_FILL: begin
        if (seq_addr_q == LAST_ADDR) begin
          state_d    = ST_SETTLE;
          seq_addr_d = seq_addr_q;
        end else begin
          state_d    = ST_FILL;
          seq_addr_d = seq_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_SETTLE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_FILL;
    endcase
  end

  // FSM outputs: sequencer write strobe and the next value of the done flag.
  always_comb begin
    fill_we     = (state_q == ST_FILL);
    init_done_d = (state_d == ST_DONE);
  end

  // Array write mux: the sequencer owns the array until init completes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = seq_addr_q;
    mem_wdata = init_line(seq_addr_q);
    if (fill_we) begin
      mem_we = 1'b1;
    end
`ifdef RAM_INIT_WRITE_EN
    else if (init_done_q && wr_en_i && addr_in_range(wr_addr_i)) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr_i;
      mem_wdata = wr_data_i;
    end
`endif
    else begin
      mem_we = 1'b0;
    end
  end

  // Read path: zeros until ready or for out-of-range addresses.
  always_comb begin
    data_d = {CACHE_LINE{1'b0}};
    if (init_done_q && addr_in_range(addr_i)) begin
      data_d = cache_mem[addr_i];
    end else begin
      data_d = {CACHE_LINE{1'b0}};
    end
  end

  // Array storage; not reset, the sequencer rewrites every line after reset.
  // Non-blocking update keeps a same-cycle read returning the old line.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      cache_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_o      = data_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_ram_init.sv
// tb_ram_init -- directed self-checking bench for ram_init (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
// Write-port checks are compiled only when RAM_INIT_WRITE_EN is defined.

module tb_ram_init;

  localparam int unsigned LINE  = 128;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic            clk;
  logic            rst_ni;
  logic [AW-1:0]   addr_i;
  logic [LINE-1:0] data_o;
  logic            init_done_o;
  logic            wr_en_i;
  logic [AW-1:0]   wr_addr_i;
  logic [LINE-1:0] wr_data_i;

  int n_tests;
  int n_fail;

  ram_init #(
    .CACHE_LINE (LINE),
    .CACHE_DEPTH(DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .addr_i     (addr_i),
    .data_o     (data_o),
    .init_done_o(init_done_o)
`ifdef RAM_INIT_WRITE_EN
    ,
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected initial line i: word j = 4*i + j.
  function automatic logic [LINE-1:0] exp_line(input int i);
    logic [LINE-1:0] l;
    for (int j = 0; j < 4; j++) l[32*j +: 32] = 32'(4 * i + j);
    return l;
  endfunction

  task automatic check(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32 edges of zero output / low done, then done high on edge 33.
  task automatic check_init_window(input string tag);
    for (int e = 1; e <= 32; e++) begin
      tick();
      check($sformatf("%s_done_lo_e%0d", tag, e), {127'd0, init_done_o}, {128{1'b0}});
      check($sformatf("%s_data_zero_e%0d", tag, e), data_o, {128{1'b0}});
    end
    tick();
    check($sformatf("%s_done_hi_e33", tag), {127'd0, init_done_o}, {127'd0, 1'b1});
  endtask

  // Read every address in order, then let the 5-bit counter wrap to 0.
  task automatic sweep(input string tag);
    logic [AW-1:0] a;
    a = 5'd0;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      addr_i = a;
      tick();
      check($sformatf("%s_rd%0d", tag, k), data_o, exp_line(k % 32));
      a = a + 5'd1;
    end
  endtask

  initial begin
    logic [LINE-1:0] c_e0, c_e31, c_e5, c_e3, c_dead;
    n_tests   = 0;
    n_fail    = 0;
    rst_ni    = 1'b0;
    addr_i    = 5'd0;
    wr_en_i   = 1'b0;
    wr_addr_i = 5'd0;
    wr_data_i = {128{1'b0}};
    c_e0   = 128'h00000003_00000002_00000001_00000000;
    c_e31  = 128'h0000007F_0000007E_0000007D_0000007C;
    c_e5   = 128'h00000017_00000016_00000015_00000014;
    c_e3   = 128'h0000000F_0000000E_0000000D_0000000C;
    c_dead = {4{32'hDEADBEEF}};

    // Reset held 5 cycles.
    repeat (5) tick();
    check("rst_data", data_o, {128{1'b0}});
    check("rst_done", {127'd0, init_done_o}, {128{1'b0}});

    @(negedge clk);
    rst_ni = 1'b1;
    check_init_window("init1");

    // Hand-computed anchor lines.
    @(negedge clk); addr_i = 5'd0;  tick(); check("entry0", data_o, c_e0);
    @(negedge clk); addr_i = 5'd31; tick(); check("entry31", data_o, c_e31);

    sweep("sweep1");

    // Hold address 5: stable output every cycle.
    @(negedge clk);
    addr_i = 5'd5;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("hold5_c%0d", c), data_o, c_e5);
    end

    // Reset mid-operation: outputs clear immediately, not at a clock edge.
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("midop_rst_done", {127'd0, init_done_o}, {128{1'b0}});
    check("midop_rst_data", data_o, {128{1'b0}});
    @(negedge clk);
    rst_ni = 1'b1;
`ifdef RAM_INIT_WRITE_EN
    // Writes attempted throughout initialisation must be dropped.
    wr_en_i   = 1'b1;
    wr_addr_i = 5'd3;
    wr_data_i = {128{1'b1}};
`endif
    // Reset again once the sequencer has reached address 10.
    repeat (10) @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("midinit_rst_done", {127'd0, init_done_o}, {128{1'b0}});
    check("midinit_rst_data", data_o, {128{1'b0}});
    @(negedge clk);
    rst_ni = 1'b1;
    addr_i = 5'd7;
    check_init_window("init2");
`ifdef RAM_INIT_WRITE_EN
    @(negedge clk);
    wr_en_i = 1'b0;
    addr_i  = 5'd3;
    tick();
    check("wr_during_init_ignored", data_o, c_e3);
`endif

    sweep("sweep2");

`ifdef RAM_INIT_WRITE_EN
    // Read-first: same-cycle read of the written address returns old data.
    @(negedge clk);
    addr_i    = 5'd3;
    wr_en_i   = 1'b1;
    wr_addr_i = 5'd3;
    wr_data_i = c_dead;
    tick();
    check("wr_read_first_old", data_o, c_e3);
    @(negedge clk);
    wr_en_i = 1'b0;
    tick();
    check("wr_new_value", data_o, c_dead);
    @(negedge clk); addr_i = 5'd4; tick(); check("wr_neighbour", data_o, exp_line(4));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
